// File: rtl/odd_parity_frame_ctrl.sv
// odd_parity_frame_ctrl: serial odd-parity frame receiver.
// Shifts in DATA_W data bits (MSB first) followed by a parity bit. It flags
// an error when the total number of ones is even, and then holds the frame on
// a valid/ready handshake.
// Optional feature macro: ODD_PARITY_ERR_CNT_EN enables the saturating error
// counter and err_clr. When the macro is undefined, err_cnt is tied to 0.
module odd_parity_frame_ctrl #(
    parameter int DATA_W    = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 frame_ready,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [DATA_W-1:0]    dout,
    output logic                 p,
    output logic                 e,
    output logic                 frame_valid,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] next_word;
    logic             frame_err;

    // A single-bit word is a plain load; wider words shift left, MSB first
    generate
        if (DATA_W == 1) begin : g_load
            assign next_word = din;
        end else begin : g_shift
            assign next_word = {dout[DATA_W-2:0], din};
        end
    endgenerate

    // Odd-parity rule: error when data plus parity hold an even count of ones
    assign frame_err = ~(^dout ^ din);

    // Frame sequencer with registered status and data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            dout        <= '0;
            p           <= 1'b0;
            e           <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (din_valid) begin
                        dout    <= next_word;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (din_valid) begin
                        p           <= din;
                        e           <= frame_err;
                        frame_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ODD_PARITY_ERR_CNT_EN
    logic err_inc;

    // The increment fires on the same edge that e is written and frame_valid rises
    assign err_inc = (state == PARITY) && din_valid && frame_err;

    // Saturating error counter; a clear wins over a simultaneous increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_odd_parity_frame_ctrl.sv
// Directed testbench for odd_parity_frame_ctrl (DATA_W=3).
// Instance a uses ERR_CNT_W=8 and instance b uses ERR_CNT_W=2. Both share the stimulus.
module tb_odd_parity_frame_ctrl;

`ifdef ODD_PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       din;
    logic       din_valid;
    logic       frame_ready;
    logic       err_clr;

    logic       busy_a, p_a, e_a, fv_a;
    logic [2:0] dout_a;
    logic [7:0] err_a;
    logic       busy_b, p_b, e_b, fv_b;
    logic [2:0] dout_b;
    logic [1:0] err_b;

    int n_checks = 0;
    int n_err    = 0;
    int exp_a    = 0;
    int exp_b    = 0;
    int e_seen   = 0;

    odd_parity_frame_ctrl #(.DATA_W(3), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .frame_ready(frame_ready), .err_clr(err_clr), .busy(busy_a), .dout(dout_a),
        .p(p_a), .e(e_a), .frame_valid(fv_a), .err_cnt(err_a)
    );

    odd_parity_frame_ctrl #(.DATA_W(3), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .frame_ready(frame_ready), .err_clr(err_clr), .busy(busy_b), .dout(dout_b),
        .p(p_b), .e(e_b), .frame_valid(fv_b), .err_cnt(err_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference error-count model, applied on the edge where frame_valid rises
    task automatic model_count(input logic err, input logic clr);
        if (clr) begin
            exp_a = 0;
            exp_b = 0;
        end else if (err && CNT_EN) begin
            if (exp_a < 255) exp_a++;
            if (exp_b < 3) exp_b++;
        end
    endtask

    task automatic clear_cnt();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        model_count(1'b0, 1'b1);
        chk("clr_a", 32'(err_a), 0);
        chk("clr_b", 32'(err_b), 0);
    endtask

    // Back-to-back frame with frame_ready already high at the parity edge
    task automatic run_frame(input logic [2:0] d, input logic pb, input logic clr);
        logic exp_e;
        exp_e = ~(^d ^ pb);
        start = 1'b1;
        tick();
        chk("busy_rise", 32'(busy_a), 1);
        start = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            din_valid = 1'b1;
            din = d[i];
            tick();
            chk("fv_low_shift", 32'(fv_a), 0);
        end
        din = pb;
        frame_ready = 1'b1;
        err_clr = clr;
        tick();
        model_count(exp_e, clr);
        chk("fv_rise", 32'(fv_a), 1);
        chk("dout", 32'(dout_a), 32'(d));
        chk("p", 32'(p_a), 32'(pb));
        chk("e", 32'(e_a), 32'(exp_e));
        chk("err_cnt_a", 32'(err_a), 32'(exp_a));
        chk("err_cnt_b", 32'(err_b), 32'(exp_b));
        if (e_a === 1'b1) e_seen++;
        din_valid = 1'b0;
        err_clr = 1'b0;
        tick();
        chk("fv_fall", 32'(fv_a), 0);
        chk("busy_fall", 32'(busy_a), 0);
        chk("dout_keep", 32'(dout_a), 32'(d));
        frame_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din = 1'b0;
        din_valid = 1'b0;
        frame_ready = 1'b0;
        err_clr = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_dout", 32'(dout_a), 0);
        chk("rst_p", 32'(p_a), 0);
        chk("rst_e", 32'(e_a), 0);
        chk("rst_fv", 32'(fv_a), 0);
        chk("rst_err", 32'(err_a), 0);
        rst_n = 1'b1;
        tick();

        // Clean frame 101 / parity 1, then error frame 110 / parity 0
        run_frame(3'b101, 1'b1, 1'b0);
        run_frame(3'b110, 1'b0, 1'b0);
        chk("err_after_one", 32'(err_a), CNT_EN ? 1 : 0);

        // Exhaustive sweep of the 16 {data,p} combinations
        clear_cnt();
        e_seen = 0;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            vv = 4'(v);
            run_frame(vv[3:1], vv[0], 1'b0);
        end
        chk("sweep_e_count", 32'(e_seen), 8);
        chk("sweep_cnt_a", 32'(err_a), CNT_EN ? 8 : 0);
        chk("sweep_cnt_b", 32'(err_b), CNT_EN ? 3 : 0);

        // Gaps, backpressure, stray din and start pulses: frame 011 / parity 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din = (i != 0);
            tick();
            din_valid = 1'b0;
            din = ~din;
            start = 1'b1;
            tick();
            tick();
            start = 1'b0;
            chk("gap_busy", 32'(busy_a), 1);
            chk("gap_fv", 32'(fv_a), 0);
        end
        din_valid = 1'b1;
        din = 1'b1;
        tick();
        chk("bp_fv_rise", 32'(fv_a), 1);
        chk("bp_dout", 32'(dout_a), 32'h3);
        for (int i = 0; i < 4; i++) begin
            din = i[0];
            start = 1'b1;
            tick();
            chk("bp_fv_hold", 32'(fv_a), 1);
            chk("bp_dout_hold", 32'(dout_a), 32'h3);
            chk("bp_p_hold", 32'(p_a), 1);
            chk("bp_e_hold", 32'(e_a), 0);
            chk("bp_err_hold", 32'(err_a), 32'(exp_a));
        end
        start = 1'b0;
        din_valid = 1'b0;
        frame_ready = 1'b1;
        tick();
        chk("bp_fv_fall", 32'(fv_a), 0);
        chk("bp_busy_fall", 32'(busy_a), 0);
        frame_ready = 1'b0;
        tick();
        chk("start_not_queued", 32'(busy_a), 0);

        // Saturation of the 2-bit counter, then a clear colliding with an increment
        clear_cnt();
        for (int i = 0; i < 5; i++) begin
            run_frame(3'b110, 1'b0, 1'b0);
        end
        chk("sat_cnt_b", 32'(err_b), CNT_EN ? 3 : 0);
        chk("sat_cnt_a", 32'(err_a), CNT_EN ? 5 : 0);
        run_frame(3'b110, 1'b0, 1'b1);
        chk("clr_prio_b", 32'(err_b), 0);
        chk("clr_prio_a", 32'(err_a), 0);

        // Raise the count again so the asynchronous reset has something to clear
        run_frame(3'b000, 1'b0, 1'b0);

        // Reset after two data bits aborts the frame at once
        start = 1'b1;
        tick();
        start = 1'b0;
        din_valid = 1'b1;
        din = 1'b1;
        tick();
        din = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        model_count(1'b0, 1'b1);
        chk("mid_rst_busy", 32'(busy_a), 0);
        chk("mid_rst_dout", 32'(dout_a), 0);
        chk("mid_rst_p", 32'(p_a), 0);
        chk("mid_rst_e", 32'(e_a), 0);
        chk("mid_rst_fv", 32'(fv_a), 0);
        chk("mid_rst_err", 32'(err_a), 0);
        din_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_fv", 32'(fv_a), 0);
        run_frame(3'b010, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
